// File: rtl/intl_pkg.sv
// intl_pkg: shared state encoding, default sizes and priority encoder for the interlock collector
package intl_pkg;
  typedef enum logic {ST_ARMED = 1'b0, ST_TRIPPED = 1'b1} state_t;
  localparam int CH_NUM_DEF    = 8;
  localparam int TS_WIDTH_DEF  = 32;
  localparam int FLT_WIDTH_DEF = 8;
  function automatic int lowest_set(input logic [31:0] v);
    lowest_set = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_set = i;
  endfunction
endpackage

// File: rtl/intl_filter.sv
// intl_filter: per-channel saturating persistence counter producing the qualified fault flag
module intl_filter #(
  parameter int FLT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fault,
  input  logic                 i_mask,
  input  logic                 i_restart,
  input  logic [FLT_WIDTH-1:0] i_filter,
  output logic                 o_qual
);
  logic [FLT_WIDTH-1:0] cnt;
  logic act;
  assign act = i_fault & i_mask;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt <= '0;
    else if (i_restart || !act) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  assign o_qual = act & (cnt >= i_filter);
endmodule

// File: rtl/intl_latch.sv
// intl_latch: masks and filters fault channels, latches the first event and holds the interlock until a clean clear
module intl_latch
  import intl_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int FLT_WIDTH = FLT_WIDTH_DEF,
  parameter int IDX_W     = CH_NUM > 1 ? $clog2(CH_NUM) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CH_NUM-1:0]    i_fault,
  input  logic [CH_NUM-1:0]    i_mask,
  input  logic [FLT_WIDTH-1:0] i_filter,
  input  logic                 i_clr,
  output logic                 o_intl,
  output logic [CH_NUM-1:0]    o_fault_latch,
  output logic                 o_first_valid,
  output logic [IDX_W-1:0]     o_first_idx,
  output logic [TS_WIDTH-1:0]  o_ts,
  output logic                 o_clr_rej
);
  state_t state;
  logic [CH_NUM-1:0] qual;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic any_raw, clr_ok;
  assign any_raw = |(i_fault & i_mask);
  assign clr_ok  = (state == ST_TRIPPED) && i_clr && !any_raw;
  assign o_intl  = (state == ST_TRIPPED);
  for (genvar k = 0; k < CH_NUM; k++) begin : g_flt
    intl_filter #(.FLT_WIDTH(FLT_WIDTH)) u_flt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_fault  (i_fault[k]),
      .i_mask   (i_mask[k]),
      .i_restart(clr_ok),
      .i_filter (i_filter),
      .o_qual   (qual[k])
    );
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) ts_cnt <= '0;
    else ts_cnt <= ts_cnt + 1'b1;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state         <= ST_ARMED;
      o_fault_latch <= '0;
      o_first_valid <= 1'b0;
      o_first_idx   <= '0;
      o_ts          <= '0;
      o_clr_rej     <= 1'b0;
    end else begin
      o_clr_rej <= 1'b0;
      if (state == ST_ARMED) begin
        if (|qual) begin
          state         <= ST_TRIPPED;
          o_fault_latch <= qual;
          o_first_valid <= 1'b1;
          o_first_idx   <= IDX_W'(lowest_set(32'(qual)));
          o_ts          <= ts_cnt;
        end
      end else if (clr_ok) begin
        state         <= ST_ARMED;
        o_fault_latch <= '0;
        o_first_valid <= 1'b0;
        o_first_idx   <= '0;
        o_ts          <= '0;
      end else begin
        // a refused clear still records anything qualifying in the same cycle
        o_fault_latch <= o_fault_latch | qual;
        o_clr_rej     <= i_clr;
      end
    end
endmodule

// File: tb/tb_intl_latch.sv
// tb_intl_latch: directed stimulus with a scoreboard of expected output events checked by a negedge monitor
module tb_intl_latch;
  typedef struct packed {
    logic        intl;
    logic [7:0]  latch;
    logic        valid;
    logic [2:0]  idx;
    logic [31:0] ts;
    logic        rej;
  } ev_t;
  logic clk = 0, rst = 1, clr = 0;
  logic [7:0] fault = '0, mask = '0, filter = '0;
  logic intl, valid, rej;
  logic [7:0] latch;
  logic [2:0] idx;
  logic [31:0] ts, tbts, t0;
  logic p_intl;
  logic [7:0] p_latch;
  ev_t sbq[$];
  ev_t e;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  intl_latch dut (
    .i_clk(clk), .i_rst(rst), .i_fault(fault), .i_mask(mask), .i_filter(filter), .i_clr(clr),
    .o_intl(intl), .o_fault_latch(latch), .o_first_valid(valid), .o_first_idx(idx), .o_ts(ts),
    .o_clr_rej(rej)
  );
  always @(posedge clk or posedge rst)
    if (rst) tbts <= '0;
    else tbts <= tbts + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, x);
    end
  endtask
  task automatic push(input logic i, input logic [7:0] l, input logic v, input logic [2:0] x,
                      input logic [31:0] t, input logic r);
    sbq.push_back({i, l, v, x, t, r});
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      p_intl  = 1'b0;
      p_latch = '0;
    end else begin
      if (intl !== p_intl || latch !== p_latch || rej) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event intl=%0b latch=%h rej=%0b", intl, latch, rej);
        end else begin
          e = sbq.pop_front();
          chk("ev_intl", 32'(intl), 32'(e.intl));
          chk("ev_latch", 32'(latch), 32'(e.latch));
          chk("ev_valid", 32'(valid), 32'(e.valid));
          chk("ev_idx", 32'(idx), 32'(e.idx));
          chk("ev_ts", ts, e.ts);
          chk("ev_rej", 32'(rej), 32'(e.rej));
        end
      end
      p_intl  = intl;
      p_latch = latch;
    end
  end
  initial begin
    cyc(2);
    chk("rst_intl", 32'(intl), 0);
    chk("rst_latch", 32'(latch), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_ts", ts, 0);
    chk("rst_rej", 32'(rej), 0);
    rst = 0;
    cyc(2);
    // basic trip, filter 2
    mask = 8'hFF; filter = 8'd2; fault = 8'h08; t0 = tbts;
    push(1, 8'h08, 1, 3'd3, t0 + 2, 0);
    cyc(3);
    fault = 8'h00; clr = 1;
    push(0, 8'h00, 0, 3'd0, 0, 0);
    cyc(1);
    clr = 0;
    cyc(2);
    // glitch rejection
    fault = 8'h02; cyc(2);
    fault = 8'h00; cyc(1);
    fault = 8'h02; cyc(2);
    fault = 8'h00; cyc(3);
    chk("glitch_intl", 32'(intl), 0);
    chk("glitch_latch", 32'(latch), 0);
    // masking and priority, filter 0
    mask = 8'hF0; filter = 8'd0; fault = 8'h0F; cyc(5);
    chk("mask_intl", 32'(intl), 0);
    fault = 8'h60; t0 = tbts;
    push(1, 8'h60, 1, 3'd5, t0, 0);
    cyc(1);
    fault = 8'h00; clr = 1;
    push(0, 8'h00, 0, 3'd0, 0, 0);
    cyc(1);
    clr = 0;
    cyc(2);
    // clear handshake, filter 1
    mask = 8'hFF; filter = 8'd1; fault = 8'h04; t0 = tbts;
    push(1, 8'h04, 1, 3'd2, t0 + 1, 0);
    cyc(2);
    clr = 1;
    push(1, 8'h04, 1, 3'd2, t0 + 1, 1);
    cyc(1);
    clr = 0;
    cyc(2);
    chk("rej_intl_held", 32'(intl), 1);
    chk("rej_pulse_gone", 32'(rej), 0);
    fault = 8'h00; cyc(1);
    clr = 1;
    push(0, 8'h00, 0, 3'd0, 0, 0);
    cyc(1);
    clr = 0;
    chk("clr_intl", 32'(intl), 0);
    chk("clr_no_rej", 32'(rej), 0);
    cyc(2);
    // sticky accumulation, rejected clear with new fault, mask change while tripped
    filter = 8'd0; fault = 8'h01; t0 = tbts;
    push(1, 8'h01, 1, 3'd0, t0, 0);
    cyc(1);
    fault = 8'h00; cyc(1);
    fault = 8'h40;
    push(1, 8'h41, 1, 3'd0, t0, 0);
    cyc(1);
    fault = 8'h80; clr = 1;
    push(1, 8'hC1, 1, 3'd0, t0, 1);
    cyc(1);
    fault = 8'h00; clr = 0; mask = 8'h00;
    cyc(2);
    chk("sticky_latch", 32'(latch), 32'hC1);
    chk("sticky_idx", 32'(idx), 0);
    chk("sticky_ts", ts, t0);
    clr = 1;
    push(0, 8'h00, 0, 3'd0, 0, 0);
    cyc(1);
    clr = 0; mask = 8'hFF;
    cyc(2);
    // asynchronous reset while tripped
    fault = 8'h08; t0 = tbts;
    push(1, 8'h08, 1, 3'd3, t0, 0);
    cyc(1);
    fault = 8'h00;
    cyc(1);
    rst = 1;
    #1;
    chk("arst_intl", 32'(intl), 0);
    chk("arst_latch", 32'(latch), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_ts", ts, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 0;
    cyc(2);
    fault = 8'h02;
    push(1, 8'h02, 1, 3'd1, 32'd2, 0);
    cyc(1);
    fault = 8'h00; clr = 1;
    push(0, 8'h00, 0, 3'd0, 0, 0);
    cyc(1);
    clr = 0;
    cyc(3);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
